evr_event_timestamp_fifo: RTL and testbench

Consumer of the EVR 64-bit timestamp {Seconds[31:0], Ticks[31:0]}. On each received event code whose latch-enable bit is set, captures the code together with the timestamp of that same cycle. Stores the pair in a first-word-fall-through FIFO that software drains through the register bridge. Overflow and drop accounting let software detect lost events.

---
 rtl/evr_pkg.sv | 19 +
 rtl/evr_sync_fifo_fwft.sv | 68 ++++++
 rtl/evr_event_timestamp_fifo.sv | 108 ++++++++++
 tb/tb_evr_event_timestamp_fifo.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evr_pkg.sv
// Shared EVR definitions: field widths, the null event code and the
// timestamp FIFO entry layout {code, seconds, ticks}.
package evr_pkg;

    localparam int EVR_CODE_W         = 8;
    localparam int EVR_TS_W           = 64;
    localparam int EVR_TSFIFO_ENTRY_W = EVR_CODE_W + EVR_TS_W;

    // Code 0 means "no event" on the link and is never latched.
    localparam logic [EVR_CODE_W-1:0] EVR_NULL_CODE = 8'h00;

    // Packed so that the entry is bit-identical to {EventCode, TimeStamp}.
    typedef struct packed {
        logic [EVR_CODE_W-1:0] code;
        logic [31:0]           seconds;
        logic [31:0]           ticks;
    } evr_ts_entry_t;

endpackage

// File: rtl/evr_sync_fifo_fwft.sv
// Generic single-clock first-word-fall-through FIFO.
// Pointers carry one extra wrap bit, so full and empty can be told apart
// without a separate counter. A push while full is accepted only when a
// pop happens in the same cycle. Flush empties the FIFO and overrides
// both push and pop.
module evr_sync_fifo_fwft #(
    parameter  int WIDTH  = 72,
    parameter  int DEPTH  = 512,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic              valid,
    output logic [ADDR_W:0]   level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Full/empty from the wrap bit, and the gated push/pop strobes.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
        do_pop  = pop & ~empty & ~flush;
        do_push = push & ~flush & (~full | do_pop);
    end

    // Pointer update; both pointers wrap modulo 2*DEPTH.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // always_ff in this design sees pre-edge values regardless of order.
        if (Reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write. On push+pop while full the write lands on the slot
    // being popped, whose old contents are already on dout this cycle.
    always_ff @(posedge Clock) begin
        // NOTE: the storage array is deliberately not reset; the pointers
        // alone define which entries are meaningful, and an unreset array
        // maps onto RAM.
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= din;
    end

    // Head entry falls through combinationally from the read pointer.
    always_comb begin
        dout  = mem[rd_ptr[ADDR_W-1:0]];
        valid = ~empty;
        level = wr_ptr - rd_ptr;
    end

endmodule

// File: rtl/evr_event_timestamp_fifo.sv
// EVR event timestamp FIFO.
// Each received event code whose latch-enable mask bit is set is captured
// together with the timestamp of the same cycle and queued in an FWFT FIFO
// that software drains. Events that find the FIFO full are dropped and
// accounted for through a sticky Overflow flag and a saturating DropCount.
module evr_event_timestamp_fifo
    import evr_pkg::*;
#(
    parameter  int DEPTH  = 512,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [EVR_TS_W-1:0]           TimeStamp,
    input  logic [EVR_CODE_W-1:0]         EventCode,
    input  logic                          EventValid,
    input  logic                          MaskWrEn,
    input  logic [EVR_CODE_W-1:0]         MaskWrAddr,
    input  logic                          MaskWrData,
    input  logic                          Flush,
    input  logic                          OverflowClr,
    output logic                          RdValid,
    output logic [EVR_TSFIFO_ENTRY_W-1:0] RdData,
    input  logic                          RdAck,
    output logic [ADDR_W:0]               FillLevel,
    output logic                          Overflow,
    output logic [15:0]                   DropCount
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    logic [(1 << EVR_CODE_W)-1:0] mask;
    logic                         s1_valid;
    logic                         s1_mask;
    evr_ts_entry_t                s1_entry;
    logic                         push_req;
    logic                         fifo_push;
    logic                         drop;

    // Latch-enable mask, one bit per event code. A write in the same cycle
    // as a lookup of that code only takes effect for later events.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            mask <= '0;
        end else if (MaskWrEn) begin
            mask[MaskWrAddr] <= MaskWrData;
        end
    end

    // Stage-1 valid flag; Flush discards whatever event is in flight.
    always_ff @(posedge Clock) begin
        if (Reset || Flush) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= EventValid;
        end
    end

    // Stage-1 payload: code, timestamp of the event cycle, and its mask bit.
    always_ff @(posedge Clock) begin
        if (EventValid) begin
            s1_entry <= '{code:    EventCode,
                          seconds: TimeStamp[63:32],
                          ticks:   TimeStamp[31:0]};
            s1_mask  <= mask[EventCode];
        end
    end

    // Qualify the captured event and decide between push and drop. While
    // full the head is valid, so RdAck always frees a slot for the push.
    always_comb begin
        push_req  = s1_valid & s1_mask & (s1_entry.code != EVR_NULL_CODE);
        fifo_push = push_req & ~Flush;
        drop      = fifo_push & (FillLevel == FULL_LEVEL) & ~RdAck;
    end

    evr_sync_fifo_fwft #(
        .WIDTH (EVR_TSFIFO_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (fifo_push),
        .pop   (RdAck),
        .flush (Flush),
        .din   (s1_entry),
        .dout  (RdData),
        .valid (RdValid),
        .level (FillLevel)
    );

    // Drop accounting; a drop in the same cycle as a clear wins and
    // restarts the count at one.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Overflow  <= 1'b0;
            DropCount <= '0;
        end else if (drop) begin
            Overflow <= 1'b1;
            if (OverflowClr)                DropCount <= 16'd1;
            else if (DropCount != 16'hFFFF) DropCount <= DropCount + 16'd1;
        end else if (OverflowClr) begin
            Overflow  <= 1'b0;
            DropCount <= '0;
        end
    end

endmodule

// File: tb/tb_evr_event_timestamp_fifo.sv
// Self-checking bench for evr_event_timestamp_fifo (DEPTH=4).
// A queue-based reference model tracks the expected FIFO contents and the
// drop accounting; every cycle the DUT outputs are compared against it.
module tb_evr_event_timestamp_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          Clock;
    logic          Reset;
    logic [63:0]   TimeStamp;
    logic [7:0]    EventCode;
    logic          EventValid;
    logic          MaskWrEn;
    logic [7:0]    MaskWrAddr;
    logic          MaskWrData;
    logic          Flush;
    logic          OverflowClr;
    logic          RdValid;
    logic [71:0]   RdData;
    logic          RdAck;
    logic [AW:0]   FillLevel;
    logic          Overflow;
    logic [15:0]   DropCount;

    evr_event_timestamp_fifo #(.DEPTH(DEPTH)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .TimeStamp   (TimeStamp),
        .EventCode   (EventCode),
        .EventValid  (EventValid),
        .MaskWrEn    (MaskWrEn),
        .MaskWrAddr  (MaskWrAddr),
        .MaskWrData  (MaskWrData),
        .Flush       (Flush),
        .OverflowClr (OverflowClr),
        .RdValid     (RdValid),
        .RdData      (RdData),
        .RdAck       (RdAck),
        .FillLevel   (FillLevel),
        .Overflow    (Overflow),
        .DropCount   (DropCount)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Reference model state.
    logic [71:0]  mq[$];
    bit [255:0]   m_mask  = '0;
    bit           p_valid = 1'b0;
    bit           p_mask  = 1'b0;
    logic [7:0]   p_code  = 8'h00;
    logic [63:0]  p_ts    = 64'h0;
    bit           m_ovf   = 1'b0;
    int unsigned  m_dc    = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance the model by one clock using the inputs applied this cycle.
    task automatic model_step();
        bit push_req;
        bit pop;
        bit drop;
        int lvl;
        if (Reset) begin
            mq.delete();
            m_mask  = '0;
            p_valid = 1'b0;
            m_ovf   = 1'b0;
            m_dc    = 0;
            return;
        end
        lvl      = mq.size();
        push_req = p_valid && p_mask && (p_code != 8'h00);
        drop     = 1'b0;
        if (Flush) begin
            mq.delete();
        end else begin
            pop = RdAck && (lvl > 0);
            if (pop) void'(mq.pop_front());
            if (push_req) begin
                if (lvl < DEPTH || pop) mq.push_back({p_code, p_ts});
                else                    drop = 1'b1;
            end
        end
        if (drop) begin
            m_ovf = 1'b1;
            if (OverflowClr)          m_dc = 1;
            else if (m_dc < 16'hFFFF) m_dc = m_dc + 1;
        end else if (OverflowClr) begin
            m_ovf = 1'b0;
            m_dc  = 0;
        end
        if (Flush) begin
            p_valid = 1'b0;
        end else begin
            p_valid = EventValid;
            if (EventValid) begin
                p_code = EventCode;
                p_ts   = TimeStamp;
                p_mask = m_mask[EventCode];
            end
        end
        if (MaskWrEn) m_mask[MaskWrAddr] = MaskWrData;
    endtask

    // One clock: update model, clock the DUT, compare, release strobes.
    task automatic step();
        model_step();
        @(posedge Clock);
        #1;
        check("rd_valid", 72'(RdValid), 72'(mq.size() != 0));
        if (mq.size() != 0) check("rd_data", RdData, mq[0]);
        check("fill_level", 72'(FillLevel), 72'(mq.size()));
        check("overflow", 72'(Overflow), 72'(m_ovf));
        check("drop_count", 72'(DropCount), 72'(m_dc));
        Reset       = 1'b0;
        EventValid  = 1'b0;
        MaskWrEn    = 1'b0;
        Flush       = 1'b0;
        OverflowClr = 1'b0;
        RdAck       = 1'b0;
        TimeStamp   = TimeStamp + 64'd1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic ev(input logic [7:0] c);
        EventValid = 1'b1;
        EventCode  = c;
        step();
    endtask

    task automatic mask_wr(input logic [7:0] c, input logic d);
        MaskWrEn   = 1'b1;
        MaskWrAddr = c;
        MaskWrData = d;
        step();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            RdAck = 1'b1;
            step();
        end
    endtask

    initial begin
        Reset       = 1'b1;
        TimeStamp   = 64'h0;
        EventCode   = 8'h00;
        EventValid  = 1'b0;
        MaskWrEn    = 1'b0;
        MaskWrAddr  = 8'h00;
        MaskWrData  = 1'b0;
        Flush       = 1'b0;
        OverflowClr = 1'b0;
        RdAck       = 1'b0;
        step();
        Reset = 1'b1;
        step();

        // Single capture with a known timestamp, visible two cycles later.
        mask_wr(8'h7D, 1'b1);
        TimeStamp = 64'h0000_0005_0000_1234;
        ev(8'h7D);
        check("early_not_valid", 72'(RdValid), 72'(0));
        step();
        check("cap_valid", 72'(RdValid), 72'(1));
        check("cap_data", RdData, 72'h7D_00000005_00001234);
        check("cap_level", 72'(FillLevel), 72'(1));
        drain(1);

        // Masked-off code and the null code are never pushed.
        mask_wr(8'h00, 1'b1);
        ev(8'h28);
        ev(8'h00);
        idle(2);
        check("null_level", 72'(FillLevel), 72'(0));
        check("null_drop", 72'(DropCount), 72'(0));

        // Overflow: six back-to-back events into four slots.
        mask_wr(8'h01, 1'b1);
        for (int i = 0; i < 6; i++) ev(8'h01);
        idle(2);
        check("ovf_level", 72'(FillLevel), 72'(4));
        check("ovf_flag", 72'(Overflow), 72'(1));
        check("ovf_count", 72'(DropCount), 72'(2));
        OverflowClr = 1'b1;
        step();
        check("clr_flag", 72'(Overflow), 72'(0));
        check("clr_count", 72'(DropCount), 72'(0));
        drain(4);

        // Push and pop together while full: no drop, level stays at DEPTH.
        for (int i = 0; i < 4; i++) ev(8'h01);
        idle(2);
        ev(8'h01);
        RdAck = 1'b1;
        step();
        idle(1);
        check("pp_level", 72'(FillLevel), 72'(4));
        check("pp_drop", 72'(DropCount), 72'(0));
        drain(4);

        // Mask write racing the same code: old bit used for that event.
        MaskWrEn   = 1'b1;
        MaskWrAddr = 8'h10;
        MaskWrData = 1'b1;
        ev(8'h10);
        idle(2);
        check("race_level", 72'(FillLevel), 72'(0));
        ev(8'h10);
        idle(2);
        check("race_next", 72'(FillLevel), 72'(1));
        drain(1);

        // Flush with stage 1 occupied and a simultaneous RdAck.
        for (int i = 0; i < 3; i++) ev(8'h01);
        idle(2);
        ev(8'h01);
        Flush = 1'b1;
        RdAck = 1'b1;
        step();
        idle(2);
        check("flush_level", 72'(FillLevel), 72'(0));
        check("flush_valid", 72'(RdValid), 72'(0));
        check("flush_drop", 72'(DropCount), 72'(0));
        ev(8'h01);
        idle(2);
        check("flush_mask", 72'(FillLevel), 72'(1));

        // Drop coinciding with OverflowClr: the drop wins, count restarts at 1.
        for (int i = 0; i < 3; i++) ev(8'h01);
        ev(8'h01);
        idle(1);
        check("pre_drop", 72'(DropCount), 72'(1));
        ev(8'h01);
        OverflowClr = 1'b1;
        step();
        check("race_clr_flag", 72'(Overflow), 72'(1));
        check("race_clr_count", 72'(DropCount), 72'(1));
        Flush = 1'b1;
        step();

        // Seconds rollover is stored verbatim.
        TimeStamp = 64'h0000_0005_FFFF_FFFF;
        ev(8'h01);
        ev(8'h01);
        idle(2);
        drain(2);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) TimeStamp = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) begin
                EventValid = 1'b1;
                case ($urandom_range(0, 5))
                    0:       EventCode = 8'h00;
                    1:       EventCode = 8'h01;
                    2:       EventCode = 8'h10;
                    3:       EventCode = 8'h28;
                    4:       EventCode = 8'h7D;
                    default: EventCode = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 15) == 0) begin
                MaskWrEn   = 1'b1;
                MaskWrAddr = ($urandom_range(0, 1) == 0) ? EventCode : 8'($urandom);
                MaskWrData = 1'($urandom);
            end
            RdAck       = ($urandom_range(0, 2) == 0);
            Flush       = ($urandom_range(0, 63) == 0);
            OverflowClr = ($urandom_range(0, 31) == 0);
            Reset       = ($urandom_range(0, 511) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
